// File: rtl/mod_counter.sv
// mod_counter: parametrised up/down modulus counter with prescaler,
// synchronous load (clamped to the count range), wrap or saturate mode,
// a one-cycle boundary pulse, a sticky boundary flag and min/max flags.
module mod_counter #(
    parameter int WIDTH    = 8,
    parameter int MODULUS  = 256,
    parameter int PRESCALE = 1,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] out,
    output logic             wrap,
    output logic             ovf,
    output logic             at_max,
    output logic             at_min
);

    // Prescaler needs at least one bit even when every enabled cycle is a step.
    localparam int               PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [WIDTH-1:0] MAX_VAL  = WIDTH'(MODULUS - 1);
    localparam logic [PW-1:0]    PRE_LAST = PW'(PRESCALE - 1);

    logic [WIDTH-1:0] out_q, out_d;
    logic [PW-1:0]    pre_q, pre_d;
    logic             wrap_q, wrap_d;
    logic             ovf_q, ovf_d;
    logic             step;

    // Loaded values above the top of the range are pinned to the top.
    function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
        return (v > MAX_VAL) ? MAX_VAL : v;
    endfunction

    // Next-state: load beats step beats hold; a boundary step sets ovf
    // even when clr_ovf is asserted on the same edge.
    always_comb begin
        out_d  = out_q;
        pre_d  = pre_q;
        wrap_d = 1'b0;
        ovf_d  = ovf_q;
        step   = 1'b0;
        if (load) begin
            out_d = clamp_load(load_val);
            pre_d = '0;
        end else begin
            if (clr_ovf) begin
                ovf_d = 1'b0;
            end
            if (en) begin
                if (pre_q == PRE_LAST) begin
                    pre_d = '0;
                    step  = 1'b1;
                end else begin
                    pre_d = pre_q + 1'b1;
                end
            end
            if (step) begin
                if (up) begin
                    if (out_q == MAX_VAL) begin
                        wrap_d = 1'b1;
                        ovf_d  = 1'b1;
                        if (SATURATE == 0) begin
                            out_d = '0;
                        end
                    end else begin
                        out_d = out_q + 1'b1;
                    end
                end else begin
                    if (out_q == '0) begin
                        wrap_d = 1'b1;
                        ovf_d  = 1'b1;
                        if (SATURATE == 0) begin
                            out_d = MAX_VAL;
                        end
                    end else begin
                        out_d = out_q - 1'b1;
                    end
                end
            end
        end
    end

    // State registers; reset overrides any pending load or step.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q  <= '0;
            pre_q  <= '0;
            wrap_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            out_q  <= out_d;
            pre_q  <= pre_d;
            wrap_q <= wrap_d;
            ovf_q  <= ovf_d;
        end
    end

    assign out    = out_q;
    assign wrap   = wrap_q;
    assign ovf    = ovf_q;
    assign at_max = (out_q == MAX_VAL);
    assign at_min = (out_q == '0);

endmodule

// File: tb/tb_mod_counter.sv
// tb_mod_counter: three counter configurations driven from shared inputs,
// compared every cycle against a modulo-arithmetic reference model, plus
// directed sequences with hand-derived expected values.
module tb_mod_counter;

    logic       clk = 1'b0;
    logic       rst, en, up, load, clr_ovf;
    logic [3:0] lv;

    logic [2:0] out0;
    logic [3:0] out1, out2;
    logic       wrap0, wrap1, wrap2, ovf0, ovf1, ovf2;
    logic       amax0, amax1, amax2, amin0, amin1, amin2;

    int n_chk = 0;
    int n_bad = 0;

    // Per-instance configuration and reference state
    int W_CFG[3]   = '{3, 4, 4};
    int M_CFG[3]   = '{8, 10, 10};
    int P_CFG[3]   = '{1, 3, 2};
    int S_CFG[3]   = '{0, 1, 0};
    int m_out[3];
    int m_pre[3];
    int m_wrap[3];
    int m_ovf[3];

    always #5 clk = ~clk;

    mod_counter #(.WIDTH(3), .MODULUS(8), .PRESCALE(1), .SATURATE(0)) u0 (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(lv[2:0]),
        .clr_ovf(clr_ovf), .out(out0), .wrap(wrap0), .ovf(ovf0),
        .at_max(amax0), .at_min(amin0));

    mod_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(3), .SATURATE(1)) u1 (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(lv),
        .clr_ovf(clr_ovf), .out(out1), .wrap(wrap1), .ovf(ovf1),
        .at_max(amax1), .at_min(amin1));

    mod_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(2), .SATURATE(0)) u2 (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(lv),
        .clr_ovf(clr_ovf), .out(out2), .wrap(wrap2), .ovf(ovf2),
        .at_max(amax2), .at_min(amin2));

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d expected=%0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: advance every instance by one clock edge.
    task automatic model_edge();
        int v;
        int bnd;
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                m_out[i] = 0; m_pre[i] = 0; m_wrap[i] = 0; m_ovf[i] = 0;
            end else if (load) begin
                v = int'(lv) % (1 << W_CFG[i]);
                m_out[i]  = (v > M_CFG[i] - 1) ? M_CFG[i] - 1 : v;
                m_pre[i]  = 0;
                m_wrap[i] = 0;
            end else begin
                m_wrap[i] = 0;
                if (clr_ovf) m_ovf[i] = 0;
                if (en) begin
                    m_pre[i]++;
                    if (m_pre[i] == P_CFG[i]) begin
                        m_pre[i] = 0;
                        bnd = up ? int'(m_out[i] == M_CFG[i] - 1) : int'(m_out[i] == 0);
                        if (bnd != 0) begin
                            m_wrap[i] = 1;
                            m_ovf[i]  = 1;
                        end
                        if (!(bnd != 0 && S_CFG[i] != 0))
                            m_out[i] = up ? (m_out[i] + 1) % M_CFG[i]
                                          : (m_out[i] + M_CFG[i] - 1) % M_CFG[i];
                    end
                end
            end
        end
    endtask

    task automatic check_model();
        check("m0_out", int'(out0), m_out[0]);
        check("m0_wrap", int'(wrap0), m_wrap[0]);
        check("m0_ovf", int'(ovf0), m_ovf[0]);
        check("m0_amax", int'(amax0), int'(m_out[0] == M_CFG[0] - 1));
        check("m0_amin", int'(amin0), int'(m_out[0] == 0));
        check("m1_out", int'(out1), m_out[1]);
        check("m1_wrap", int'(wrap1), m_wrap[1]);
        check("m1_ovf", int'(ovf1), m_ovf[1]);
        check("m1_amax", int'(amax1), int'(m_out[1] == M_CFG[1] - 1));
        check("m1_amin", int'(amin1), int'(m_out[1] == 0));
        check("m2_out", int'(out2), m_out[2]);
        check("m2_wrap", int'(wrap2), m_wrap[2]);
        check("m2_ovf", int'(ovf2), m_ovf[2]);
        check("m2_amax", int'(amax2), int'(m_out[2] == M_CFG[2] - 1));
        check("m2_amin", int'(amin2), int'(m_out[2] == 0));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_model();
    endtask

    task automatic drive(input logic r, input logic ld, input logic e, input logic u,
                         input logic c, input logic [3:0] v);
        rst = r; load = ld; en = e; up = u; clr_ovf = c; lv = v;
    endtask

    initial begin
        logic [1:0] en_seq [4];
        en_seq = '{1'b1, 1'b0, 1'b0, 1'b1};
        drive(1, 1, 1, 1, 0, 4'd5);

        // Reset held two cycles with load and en active
        tick(); tick();
        check("rst_out", int'(out0), 0);
        check("rst_ovf", int'(ovf0), 0);
        check("rst_wrap", int'(wrap0), 0);
        check("rst_amin", int'(amin0), 1);
        check("rst_amax", int'(amax0), 0);

        // Up count with wrap on the 8-value counter
        drive(0, 0, 1, 1, 0, 4'd0);
        for (int k = 1; k <= 9; k++) begin
            tick();
            check("upw_out", int'(out0), k % 8);
            check("upw_wrap", int'(wrap0), int'(k == 8));
            check("upw_ovf", int'(ovf0), int'(k >= 8));
        end

        // Down count, saturating, prescale 3
        drive(0, 1, 0, 0, 0, 4'd2);
        tick();
        check("dsat_load", int'(out1), 2);
        drive(0, 0, 1, 0, 0, 4'd0);
        for (int k = 1; k <= 12; k++) begin
            tick();
            check("dsat_out", int'(out1), (k <= 2) ? 2 : (k <= 5) ? 1 : 0);
            check("dsat_wrap", int'(wrap1), int'(k == 9 || k == 12));
        end

        // Load clamp beats en, restarts prescaler
        drive(0, 0, 1, 1, 0, 4'd0);
        tick();
        drive(0, 1, 1, 1, 0, 4'd15);
        tick();
        check("ldc_out", int'(out2), 9);
        check("ldc_amax", int'(amax2), 1);
        check("ldc_wrap", int'(wrap2), 0);
        drive(0, 0, 1, 1, 0, 4'd0);
        tick();
        check("ldc_pre", int'(out2), 9);
        tick();
        check("ldc_step", int'(out2), 0);
        check("ldc_swrap", int'(wrap2), 1);

        // Sticky flag: set wins over clear on the same edge
        drive(0, 1, 0, 1, 0, 4'd7);
        tick();
        drive(0, 0, 1, 1, 1, 4'd0);
        tick();
        check("race_ovf", int'(ovf0), 1);
        check("race_out", int'(out0), 0);
        check("race_wrap", int'(wrap0), 1);
        drive(0, 0, 0, 1, 1, 4'd0);
        tick();
        check("clr_ovf", int'(ovf0), 0);
        check("clr_wrap", int'(wrap0), 0);

        // Freeze: prescaler holds while en is low
        drive(0, 1, 0, 1, 0, 4'd0);
        tick();
        for (int k = 0; k < 4; k++) begin
            drive(0, 0, en_seq[k][0], 1, 0, 4'd0);
            tick();
            check("frz_out", int'(out2), (k == 3) ? 1 : 0);
        end

        // Randomised traffic against the reference model
        for (int k = 0; k < 600; k++) begin
            rst     = ($urandom_range(0, 49) == 0);
            load    = ($urandom_range(0, 7) == 0);
            en      = ($urandom_range(0, 3) != 0);
            up      = ($urandom_range(0, 3) != 0) ^ (k >= 300);
            clr_ovf = load ? 1'b0 : ($urandom_range(0, 7) == 0);
            lv      = 4'($urandom_range(0, 15));
            tick();
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
